// File: rtl/reg_readback.sv
// Read responder for a register bank: indexes a packed register bus on request
// and returns the value through a 2-entry response buffer with 1-cycle latency.
module reg_readback #(
  parameter int              width      = 32,
  parameter int              num_regs   = 8,
  parameter int              addr_width = 3,
  parameter logic [width-1:0] err_value = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [width*num_regs-1:0] reg_bus,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [addr_width-1:0]     req_addr,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [width-1:0]          rsp_data,
  output logic                      rsp_err,
  output logic [15:0]               rd_count
);

  localparam logic [addr_width:0] num_regs_lim = (addr_width+1)'(num_regs);

  logic [width-1:0] buf_data [2];
  logic             buf_err  [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic [width-1:0] hold_data;
  logic             hold_err;

  logic             push;
  logic             pop;
  logic             in_range;
  logic [width-1:0] sel_data;
  logic [width-1:0] push_data;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < num_regs; i++) begin
      if (req_addr == addr_width'(i)) sel_data = reg_bus[i*width +: width];
    end
  end

  assign in_range  = ({1'b0, req_addr} < num_regs_lim);
  assign push_data = in_range ? sel_data : err_value;

  // req_ready looks only at occupancy so rsp_ready never reaches it combinationally
  assign req_ready = (count != 2'd2) && !reset;
  assign rsp_valid = (count != 2'd0);
  assign push      = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;

  // An empty buffer shows the last popped entry rather than a stale slot
  assign rsp_data = rsp_valid ? buf_data[rd_ptr] : hold_data;
  assign rsp_err  = rsp_valid ? buf_err[rd_ptr]  : hold_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_err[i]  <= 1'b0;
      end
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      hold_data <= '0;
      hold_err  <= 1'b0;
      rd_count  <= 16'd0;
    end else begin
      if (push) begin
        buf_data[wr_ptr] <= push_data;
        buf_err[wr_ptr]  <= !in_range;
        wr_ptr           <= ~wr_ptr;
        rd_count         <= rd_count + 16'd1;
      end
      if (pop) begin
        rd_ptr    <= ~rd_ptr;
        hold_data <= buf_data[rd_ptr];
        hold_err  <= buf_err[rd_ptr];
      end
      if (push && !pop)      count <= count + 2'd1;
      else if (pop && !push) count <= count - 2'd1;
    end
  end

endmodule

// File: tb/tb_reg_readback.sv
// Bench for reg_readback: occupancy model plus response scoreboard, and a
// second instance with a short register bank for the out-of-range path.
module tb_reg_readback;

  logic         clk;
  logic         reset;
  logic [255:0] reg_bus;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_addr;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [31:0]  rsp_data;
  logic         rsp_err;
  logic [15:0]  rd_count;

  logic         oor_req_valid;
  logic         oor_req_ready;
  logic [2:0]   oor_req_addr;
  logic         oor_rsp_valid;
  logic         oor_rsp_ready;
  logic [31:0]  oor_rsp_data;
  logic         oor_rsp_err;
  logic [15:0]  oor_rd_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [32:0] sb[$];
  int          m_count;
  logic [15:0] m_rd;
  logic        m_push;
  logic        m_pop;
  logic [32:0] e;

  reg_readback dut (
    .clk(clk), .reset(reset), .reg_bus(reg_bus),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rd_count(rd_count)
  );

  reg_readback #(.width(32), .num_regs(6), .addr_width(3), .err_value(32'hDEAD_BEEF)) dut_oor (
    .clk(clk), .reset(reset), .reg_bus(reg_bus[191:0]),
    .req_valid(oor_req_valid), .req_ready(oor_req_ready), .req_addr(oor_req_addr),
    .rsp_valid(oor_rsp_valid), .rsp_ready(oor_rsp_ready), .rsp_data(oor_rsp_data),
    .rsp_err(oor_rsp_err), .rd_count(oor_rd_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model checks at the falling edge; inputs change 2 time units after the rising edge.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      m_count = 0;
      m_rd    = 16'd0;
    end else begin
      chk("req_ready", {31'd0, req_ready}, {31'd0, m_count != 2});
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_count != 0});
      chk("rd_count", {16'd0, rd_count}, {16'd0, m_rd});
      m_pop  = (m_count != 0) && rsp_ready;
      m_push = req_valid && (m_count != 2);
      if (m_pop) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $error("FAIL sb_underflow: observed pop expected none");
        end else begin
          e = sb.pop_front();
          chk("rsp_data", rsp_data, e[31:0]);
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, e[32]});
        end
      end
      if (m_push) begin
        sb.push_back({1'b0, reg_bus[req_addr*32 +: 32]});
        m_rd = m_rd + 16'd1;
      end
      m_count = m_count + int'(m_push) - int'(m_pop);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_accept();
    logic ok;
    int   n;
    n = 0;
    forever begin
      @(negedge clk);
      ok = req_ready;
      tick();
      if (ok) break;
      n++;
      if (n > 20) begin
        n_cmp++;
        n_err++;
        $error("FAIL accept_timeout: observed stalled expected accept within 20 cycles");
        break;
      end
    end
  endtask

  task automatic send(input logic [2:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    wait_accept();
    req_valid = 1'b0;
  endtask

  task automatic oor_send(input logic [2:0] a);
    oor_req_valid = 1'b1;
    oor_req_addr  = a;
    @(negedge clk);
    chk("oor_req_ready", {31'd0, oor_req_ready}, 32'd1);
    tick();
    oor_req_valid = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    req_valid     = 1'b0;
    req_addr      = 3'd0;
    rsp_ready     = 1'b1;
    reg_bus       = '0;
    oor_req_valid = 1'b0;
    oor_req_addr  = 3'd0;
    oor_rsp_ready = 1'b1;

    tick();
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_rd_count", {16'd0, rd_count}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("rel_req_ready", {31'd0, req_ready}, 32'd1);

    // single read
    reg_bus[5*32 +: 32] = 32'h1234_5678;
    send(3'd5);
    chk("single_valid", {31'd0, rsp_valid}, 32'd1);
    chk("single_data", rsp_data, 32'h1234_5678);
    chk("single_err", {31'd0, rsp_err}, 32'd0);
    chk("single_count", {16'd0, rd_count}, 32'd1);
    tick();

    // out-of-range on the 6-register instance
    oor_send(3'd7);
    chk("oor7_valid", {31'd0, oor_rsp_valid}, 32'd1);
    chk("oor7_err", {31'd0, oor_rsp_err}, 32'd1);
    chk("oor7_data", oor_rsp_data, 32'hDEAD_BEEF);
    chk("oor7_count", {16'd0, oor_rd_count}, 32'd1);
    oor_send(3'd5);
    chk("oor5_err", {31'd0, oor_rsp_err}, 32'd0);
    chk("oor5_data", oor_rsp_data, 32'h1234_5678);
    chk("oor5_count", {16'd0, oor_rd_count}, 32'd2);
    oor_send(3'd6);
    chk("oor6_err", {31'd0, oor_rsp_err}, 32'd1);
    chk("oor6_data", oor_rsp_data, 32'hDEAD_BEEF);
    chk("oor6_count", {16'd0, oor_rd_count}, 32'd3);
    tick();

    // streaming
    for (int i = 0; i < 8; i++) reg_bus[i*32 +: 32] = i * 32'h1111;
    for (int i = 0; i < 8; i++) send(3'(i));
    repeat (3) tick();

    // back-pressure
    rsp_ready = 1'b0;
    reg_bus[1*32 +: 32] = 32'hA1A1_0001;
    reg_bus[2*32 +: 32] = 32'hB2B2_0002;
    reg_bus[3*32 +: 32] = 32'hC3C3_0003;
    send(3'd1);
    send(3'd2);
    req_valid = 1'b1;
    req_addr  = 3'd3;
    for (int i = 0; i < 3; i++) begin
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      chk("bp_hold_data", rsp_data, 32'hA1A1_0001);
      tick();
    end
    reg_bus[3*32 +: 32] = 32'h3333_ABCD;
    rsp_ready = 1'b1;
    wait_accept();
    req_valid = 1'b0;
    repeat (4) tick();

    // reset with the buffer full
    rsp_ready = 1'b0;
    send(3'd4);
    send(3'd6);
    chk("full_req_ready", {31'd0, req_ready}, 32'd0);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("arst_rd_count", {16'd0, rd_count}, 32'd0);
    chk("arst_req_ready", {31'd0, req_ready}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("post_req_ready", {31'd0, req_ready}, 32'd1);
    chk("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    rsp_ready = 1'b1;
    reg_bus[7*32 +: 32] = 32'h7777_ABCD;
    send(3'd7);
    chk("fresh_data", rsp_data, 32'h7777_ABCD);
    chk("fresh_count", {16'd0, rd_count}, 32'd1);

    // counter wrap: 65536 more reads for 65537 since reset
    for (int i = 0; i < 65536; i++) begin
      reg_bus[(i%8)*32 +: 32] = i ^ 32'h5A5A_0000;
      send(3'(i % 8));
    end
    repeat (3) tick();
    chk("wrap_count", {16'd0, rd_count}, 32'd1);
    chk("wrap_idle", {31'd0, rsp_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
